// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle of the per-channel request/command buses and the pin-level SDRAM
// command bus. The arbiter uses the slave view; the sub-engines and pads use
// the master view.
interface sdram_cmd_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16,
  parameter int DQM_W  = 2
);
  logic                    init_done;
  logic [N_CH-1:0]         ch_req;
  logic [N_CH-1:0]         ch_gnt;
  logic [N_CH*4-1:0]       ch_cmd;
  logic [N_CH-1:0]         ch_cke;
  logic [N_CH*ADDR_W-1:0]  ch_addr;
  logic [N_CH*BA_W-1:0]    ch_ba;
  logic [N_CH*DQM_W-1:0]   ch_dqm;
  logic [N_CH*DQ_W-1:0]    ch_dq_out;
  logic [N_CH-1:0]         ch_dq_oe;
  logic                    dram_cs_n;
  logic                    dram_ras_n;
  logic                    dram_cas_n;
  logic                    dram_we_n;
  logic                    dram_cke;
  logic [ADDR_W-1:0]       dram_addr;
  logic [BA_W-1:0]         dram_ba;
  logic [DQM_W-1:0]        dram_dqm;
  logic [DQ_W-1:0]         dram_dq_out;
  logic                    dram_dq_oe;
  logic [2:0]              active_ch;
  logic                    bus_busy;
  logic                    refresh_urgent;

  modport slave (
    input  init_done, ch_req, ch_cmd, ch_cke, ch_addr, ch_ba, ch_dqm,
           ch_dq_out, ch_dq_oe,
    output ch_gnt, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_cke,
           dram_addr, dram_ba, dram_dqm, dram_dq_out, dram_dq_oe,
           active_ch, bus_busy, refresh_urgent
  );

  modport master (
    output init_done, ch_req, ch_cmd, ch_cke, ch_addr, ch_ba, ch_dqm,
           ch_dq_out, ch_dq_oe,
    input  ch_gnt, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_cke,
           dram_addr, dram_ba, dram_dqm, dram_dq_out, dram_dq_oe,
           active_ch, bus_busy, refresh_urgent
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Registered N-channel owner arbiter for the SDRAM command/data bus.
// Requests and init_done are registered first, so a grant or release lands
// two edges after the request edge. The owner keeps the bus until it drops
// its request; every ownership change is followed by TURN_CYC NOP cycles.
module sdram_cmd_arbiter #(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = 13,
  parameter int BA_W     = 2,
  parameter int DQ_W     = 16,
  parameter int DQM_W    = 2,
  parameter int INIT_CH  = 0,
  parameter int REF_CH   = 2,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 64
) (
  input logic               clk,
  input logic               rst,
  sdram_cmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_TURN = 2'd2} state_t;

  localparam logic [3:0]    CMD_NOP = 4'b0111;
  localparam int            HW      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX    = HW'(MAX_HOLD);

  if (REF_CH >= N_CH || INIT_CH >= N_CH || N_CH < 2 || N_CH > 8 ||
      TURN_CYC < 1 || TURN_CYC > 7) begin : g_param_err
    $error("sdram_cmd_arbiter: REF_CH/INIT_CH/N_CH/TURN_CYC out of range");
  end

  state_t              state_r, state_nxt_s;
  logic [2:0]          owner_r, owner_nxt_s, ptr_r, ptr_nxt_s;
  logic [2:0]          turn_cnt_r, turn_nxt_s;
  logic [N_CH-1:0]     req_r;
  logic                init_done_r;
  logic [7:0]          req8_s, gnt_r, gnt_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic [HW-1:0]       hold_cnt_r, hold_nxt_s;
  logic                urgent_r, urgent_nxt_s;
  logic                win_vld_s, grant_ref_s;
  logic [2:0]          win_idx_s;
  logic [3:0]          cmd_r, cmd_nxt_s;
  logic                cke_r, cke_nxt_s, oe_r, oe_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [BA_W-1:0]     ba_r, ba_nxt_s;
  logic [DQM_W-1:0]    dqm_r, dqm_nxt_s;
  logic [DQ_W-1:0]     dq_r, dq_nxt_s;

  // Per-channel views padded to 8 entries so a 3-bit owner index fits exactly.
  logic [3:0]          cmd_a  [8];
  logic [ADDR_W-1:0]   addr_a [8];
  logic [BA_W-1:0]     ba_a   [8];
  logic [DQM_W-1:0]    dqm_a  [8];
  logic [DQ_W-1:0]     dq_a   [8];
  logic [7:0]          cke_v, oe_v;

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < N_CH) begin : g_on
      assign cmd_a[i]  = bus.ch_cmd[4*i +: 4];
      assign addr_a[i] = bus.ch_addr[ADDR_W*i +: ADDR_W];
      assign ba_a[i]   = bus.ch_ba[BA_W*i +: BA_W];
      assign dqm_a[i]  = bus.ch_dqm[DQM_W*i +: DQM_W];
      assign dq_a[i]   = bus.ch_dq_out[DQ_W*i +: DQ_W];
      assign cke_v[i]  = bus.ch_cke[i];
      assign oe_v[i]   = bus.ch_dq_oe[i];
    end else begin : g_off
      assign cmd_a[i]  = CMD_NOP;
      assign addr_a[i] = {ADDR_W{1'b0}};
      assign ba_a[i]   = {BA_W{1'b0}};
      assign dqm_a[i]  = {DQM_W{1'b1}};
      assign dq_a[i]   = {DQ_W{1'b0}};
      assign cke_v[i]  = 1'b0;
      assign oe_v[i]   = 1'b0;
    end
  end

  assign req8_s = 8'(req_r);

  // Pick the eligible winner: init channel only before init_done, then
  // refresh first, otherwise round-robin from ptr+1 skipping the refresh channel.
  always_comb begin
    logic [3:0] sum_v;
    win_vld_s = 1'b0;
    win_idx_s = 3'd0;
    sum_v     = 4'd0;
    if (!init_done_r) begin
      if (req8_s[INIT_CH]) begin
        win_vld_s = 1'b1;
        win_idx_s = 3'(INIT_CH);
      end else begin
        win_vld_s = 1'b0;
      end
    end else if (req8_s[REF_CH]) begin
      win_vld_s = 1'b1;
      win_idx_s = 3'(REF_CH);
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        sum_v = {1'b0, ptr_r} + 4'(k);
        if (sum_v >= 4'(N_CH)) begin
          sum_v = sum_v - 4'(N_CH);
        end else begin
          sum_v = sum_v;
        end
        if (!win_vld_s && sum_v[2:0] != 3'(REF_CH) && req8_s[sum_v[2:0]]) begin
          win_vld_s = 1'b1;
          win_idx_s = sum_v[2:0];
        end else begin
          win_vld_s = win_vld_s;
        end
      end
    end
  end

  // Next-state, grant and pin values; the pins show NOP whenever no owner drives.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    turn_nxt_s  = turn_cnt_r;
    gnt_nxt_s   = gnt_r;
    busy_nxt_s  = busy_r;
    grant_ref_s = 1'b0;
    cmd_nxt_s   = CMD_NOP;
    cke_nxt_s   = cke_r;
    addr_nxt_s  = addr_r;
    ba_nxt_s    = ba_r;
    dqm_nxt_s   = {DQM_W{1'b1}};
    dq_nxt_s    = dq_r;
    oe_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_nxt_s = ST_OWN;
          owner_nxt_s = win_idx_s;
          gnt_nxt_s   = 8'(8'd1 << win_idx_s);
          busy_nxt_s  = 1'b1;
          grant_ref_s = (win_idx_s == 3'(REF_CH));
          if (win_idx_s != 3'(REF_CH)) begin
            ptr_nxt_s = win_idx_s;
          end else begin
            ptr_nxt_s = ptr_r;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (req8_s[owner_r]) begin
          cmd_nxt_s  = cmd_a[owner_r];
          cke_nxt_s  = cke_v[owner_r];
          addr_nxt_s = addr_a[owner_r];
          ba_nxt_s   = ba_a[owner_r];
          dqm_nxt_s  = dqm_a[owner_r];
          dq_nxt_s   = dq_a[owner_r];
          oe_nxt_s   = oe_v[owner_r];
        end else begin
          state_nxt_s = ST_TURN;
          gnt_nxt_s   = 8'd0;
          busy_nxt_s  = 1'b0;
          turn_nxt_s  = 3'(TURN_CYC - 1);
        end
      end
      ST_TURN: begin
        if (turn_cnt_r == 3'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          turn_nxt_s = turn_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 8'd0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Refresh wait counter: counts while refresh waits behind a busy bus.
  always_comb begin
    if (!req8_s[REF_CH] || grant_ref_s) begin
      hold_nxt_s = {HW{1'b0}};
    end else if (state_r != ST_IDLE &&
                 !(state_r == ST_OWN && owner_r == 3'(REF_CH)) &&
                 hold_cnt_r < HMAX) begin
      hold_nxt_s = hold_cnt_r + 1'b1;
    end else begin
      hold_nxt_s = hold_cnt_r;
    end
    urgent_nxt_s = (MAX_HOLD != 0) && (hold_cnt_r >= HMAX);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request sampling, grant/status and registered pin values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r       <= {N_CH{1'b0}};
      init_done_r <= 1'b0;
      owner_r     <= 3'd0;
      ptr_r       <= 3'(N_CH - 1);
      turn_cnt_r  <= 3'd0;
      gnt_r       <= 8'd0;
      busy_r      <= 1'b0;
      hold_cnt_r  <= {HW{1'b0}};
      urgent_r    <= 1'b0;
      cmd_r       <= CMD_NOP;
      cke_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      ba_r        <= {BA_W{1'b0}};
      dqm_r       <= {DQM_W{1'b1}};
      dq_r        <= {DQ_W{1'b0}};
      oe_r        <= 1'b0;
    end else begin
      req_r       <= bus.ch_req;
      init_done_r <= bus.init_done;
      owner_r     <= owner_nxt_s;
      ptr_r       <= ptr_nxt_s;
      turn_cnt_r  <= turn_nxt_s;
      gnt_r       <= gnt_nxt_s;
      busy_r      <= busy_nxt_s;
      hold_cnt_r  <= hold_nxt_s;
      urgent_r    <= urgent_nxt_s;
      cmd_r       <= cmd_nxt_s;
      cke_r       <= cke_nxt_s;
      addr_r      <= addr_nxt_s;
      ba_r        <= ba_nxt_s;
      dqm_r       <= dqm_nxt_s;
      dq_r        <= dq_nxt_s;
      oe_r        <= oe_nxt_s;
    end
  end

  assign bus.ch_gnt         = gnt_r[N_CH-1:0];
  assign bus.bus_busy       = busy_r;
  assign bus.active_ch      = owner_r;
  assign bus.refresh_urgent = urgent_r;
  assign bus.dram_cs_n      = cmd_r[3];
  assign bus.dram_ras_n     = cmd_r[2];
  assign bus.dram_cas_n     = cmd_r[1];
  assign bus.dram_we_n      = cmd_r[0];
  assign bus.dram_cke       = cke_r;
  assign bus.dram_addr      = addr_r;
  assign bus.dram_ba        = ba_r;
  assign bus.dram_dqm       = dqm_r;
  assign bus.dram_dq_out    = dq_r;
  assign bus.dram_dq_oe     = oe_r;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: 4 channels, init on ch0, refresh on
// ch3, one turnaround cycle, refresh hold limit of 8 cycles.
module tb_sdram_cmd_arbiter;
  localparam int N_CH = 4, ADDR_W = 13, BA_W = 2, DQ_W = 16, DQM_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  sdram_cmd_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .BA_W(BA_W),
                         .DQ_W(DQ_W), .DQM_W(DQM_W)) bus ();

  sdram_cmd_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W),
                      .DQM_W(DQM_W), .INIT_CH(0), .REF_CH(3), .TURN_CYC(1),
                      .MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [3:0] cmd, input logic cke,
                        input logic [ADDR_W-1:0] addr, input logic [BA_W-1:0] ba,
                        input logic [DQM_W-1:0] dqm, input logic [DQ_W-1:0] dq,
                        input logic oe);
    bus.ch_cmd[4*ch +: 4]              = cmd;
    bus.ch_cke[ch]                     = cke;
    bus.ch_addr[ADDR_W*ch +: ADDR_W]   = addr;
    bus.ch_ba[BA_W*ch +: BA_W]         = ba;
    bus.ch_dqm[DQM_W*ch +: DQM_W]      = dqm;
    bus.ch_dq_out[DQ_W*ch +: DQ_W]     = dq;
    bus.ch_dq_oe[ch]                   = oe;
  endtask

  function automatic logic [3:0] pin_cmd();
    return {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
  endfunction

  task automatic test_reset();
    step(2);
    vec_cnt++;
    if ({bus.ch_gnt, bus.bus_busy, bus.active_ch, bus.refresh_urgent} !== 9'b0000_0_000_0) begin
      err_cnt++;
      $display("FAIL reset_status: got gnt=%b busy=%b act=%0d urg=%b, want all 0",
               bus.ch_gnt, bus.bus_busy, bus.active_ch, bus.refresh_urgent);
    end
    vec_cnt++;
    if ({pin_cmd(), bus.dram_cke, bus.dram_dqm, bus.dram_dq_oe} !== {4'b0111, 1'b0, 2'b11, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_cmd: got cmd=%b cke=%b dqm=%b oe=%b, want 0111 0 11 0",
               pin_cmd(), bus.dram_cke, bus.dram_dqm, bus.dram_dq_oe);
    end
    vec_cnt++;
    if ({bus.dram_addr, bus.dram_ba, bus.dram_dq_out} !== 31'd0) begin
      err_cnt++;
      $display("FAIL reset_data: got addr=%h ba=%h dq=%h, want 0",
               bus.dram_addr, bus.dram_ba, bus.dram_dq_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_grant();
    bus.ch_req = 4'b1111;
    step(1);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL init_latency: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.bus_busy, bus.active_ch} !== {4'b0001, 1'b1, 3'd0}) begin
      err_cnt++;
      $display("FAIL init_grant: got gnt=%b busy=%b act=%0d, want 0001 1 0",
               bus.ch_gnt, bus.bus_busy, bus.active_ch);
    end
    set_ch(0, 4'b0010, 1'b1, 13'h0400, 2'b01, 2'b00, 16'h0000, 1'b0);
    set_ch(1, 4'b0001, 1'b0, 13'h1fff, 2'b10, 2'b11, 16'hffff, 1'b1);
    step(1);
    vec_cnt++;
    if ({pin_cmd(), bus.dram_cke, bus.dram_addr, bus.dram_ba, bus.dram_dqm, bus.dram_dq_oe}
        !== {4'b0010, 1'b1, 13'h0400, 2'b01, 2'b00, 1'b0}) begin
      err_cnt++;
      $display("FAIL owner_pins: got cmd=%b cke=%b addr=%h ba=%b dqm=%b oe=%b, want 0010 1 0400 01 00 0",
               pin_cmd(), bus.dram_cke, bus.dram_addr, bus.dram_ba, bus.dram_dqm, bus.dram_dq_oe);
    end
    step(5);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0001) begin
      err_cnt++;
      $display("FAIL init_exclusive: got gnt=%b, want 0001", bus.ch_gnt);
    end
  endtask

  task automatic test_release();
    bus.ch_req[0] = 1'b0;
    step(1);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0001) begin
      err_cnt++;
      $display("FAIL release_latency: got gnt=%b, want 0001", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.bus_busy, pin_cmd(), bus.dram_dqm, bus.dram_dq_oe, bus.dram_cke}
        !== {4'b0000, 1'b0, 4'b0111, 2'b11, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL release_nop: got gnt=%b busy=%b cmd=%b dqm=%b oe=%b cke=%b, want 0000 0 0111 11 0 1",
               bus.ch_gnt, bus.bus_busy, pin_cmd(), bus.dram_dqm, bus.dram_dq_oe, bus.dram_cke);
    end
    step(3);
    vec_cnt++;
    if ({bus.ch_gnt, pin_cmd()} !== {4'b0000, 4'b0111}) begin
      err_cnt++;
      $display("FAIL init_block_others: got gnt=%b cmd=%b, want 0000 0111", bus.ch_gnt, pin_cmd());
    end
  endtask

  task automatic test_ref_priority();
    bus.ch_req    = 4'b1010;
    bus.init_done = 1'b1;
    step(1);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL ref_latency: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.active_ch} !== {4'b1000, 3'd3}) begin
      err_cnt++;
      $display("FAIL ref_first: got gnt=%b act=%0d, want 1000 3", bus.ch_gnt, bus.active_ch);
    end
    bus.ch_req = 4'b0010;
    step(2);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL ref_release: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL turn_gap: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.active_ch} !== {4'b0010, 3'd1}) begin
      err_cnt++;
      $display("FAIL next_after_turn: got gnt=%b act=%0d, want 0010 1", bus.ch_gnt, bus.active_ch);
    end
  endtask

  task automatic test_hold_limit();
    bus.ch_req[3] = 1'b1;
    step(9);
    vec_cnt++;
    if (bus.refresh_urgent !== 1'b0) begin
      err_cnt++;
      $display("FAIL urgent_early: got %b, want 0", bus.refresh_urgent);
    end
    step(1);
    vec_cnt++;
    if ({bus.refresh_urgent, bus.ch_gnt} !== {1'b1, 4'b0010}) begin
      err_cnt++;
      $display("FAIL urgent_rise: got urg=%b gnt=%b, want 1 0010", bus.refresh_urgent, bus.ch_gnt);
    end
    step(10);
    vec_cnt++;
    if ({bus.refresh_urgent, bus.ch_gnt} !== {1'b1, 4'b0010}) begin
      err_cnt++;
      $display("FAIL no_preempt: got urg=%b gnt=%b, want 1 0010", bus.refresh_urgent, bus.ch_gnt);
    end
    bus.ch_req[1] = 1'b0;
    step(2);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL hold_release: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(2);
    vec_cnt++;
    if ({bus.ch_gnt, bus.refresh_urgent} !== {4'b1000, 1'b1}) begin
      err_cnt++;
      $display("FAIL ref_after_hold: got gnt=%b urg=%b, want 1000 1", bus.ch_gnt, bus.refresh_urgent);
    end
    step(1);
    vec_cnt++;
    if (bus.refresh_urgent !== 1'b0) begin
      err_cnt++;
      $display("FAIL urgent_clear: got %b, want 0", bus.refresh_urgent);
    end
    bus.ch_req = 4'b0000;
    step(4);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.ch_req = 4'b0111;
    step(2);
    for (int g = 0; g < 6; g++) begin
      exp_gnt = 4'(4'd1 << (g % 3));
      vec_cnt++;
      if ({bus.ch_gnt, bus.active_ch} !== {exp_gnt, 3'(g % 3)}) begin
        err_cnt++;
        $display("FAIL rr_grant_%0d: got gnt=%b act=%0d, want %b %0d",
                 g, bus.ch_gnt, bus.active_ch, exp_gnt, g % 3);
      end
      step(3);
      bus.ch_req[g % 3] = 1'b0;
      step(2);
      vec_cnt++;
      if (bus.ch_gnt !== 4'b0000) begin
        err_cnt++;
        $display("FAIL rr_release_%0d: got gnt=%b, want 0000", g, bus.ch_gnt);
      end
      bus.ch_req[g % 3] = 1'b1;
      step(2);
    end
    bus.ch_req = 4'b0000;
    step(4);
  endtask

  task automatic test_mid_reset();
    set_ch(1, 4'b0100, 1'b1, 13'h0123, 2'b11, 2'b01, 16'ha5c3, 1'b1);
    bus.ch_req = 4'b0010;
    step(2);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0010) begin
      err_cnt++;
      $display("FAIL mr_grant: got gnt=%b, want 0010", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({pin_cmd(), bus.dram_cke, bus.dram_dq_oe, bus.dram_dq_out, bus.dram_dqm}
        !== {4'b0100, 1'b1, 1'b1, 16'ha5c3, 2'b01}) begin
      err_cnt++;
      $display("FAIL mr_write_pins: got cmd=%b cke=%b oe=%b dq=%h dqm=%b, want 0100 1 1 a5c3 01",
               pin_cmd(), bus.dram_cke, bus.dram_dq_oe, bus.dram_dq_out, bus.dram_dqm);
    end
    rst = 1'b1;
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.bus_busy, bus.active_ch, pin_cmd(), bus.dram_cke, bus.dram_dq_oe,
         bus.dram_dqm, bus.dram_dq_out}
        !== {4'b0000, 1'b0, 3'd0, 4'b0111, 1'b0, 1'b0, 2'b11, 16'h0000}) begin
      err_cnt++;
      $display("FAIL mr_reset: got gnt=%b busy=%b act=%0d cmd=%b cke=%b oe=%b dqm=%b dq=%h, want reset values",
               bus.ch_gnt, bus.bus_busy, bus.active_ch, pin_cmd(), bus.dram_cke,
               bus.dram_dq_oe, bus.dram_dqm, bus.dram_dq_out);
    end
    rst = 1'b0;
    step(1);
    vec_cnt++;
    if (bus.ch_gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL mr_relatency: got gnt=%b, want 0000", bus.ch_gnt);
    end
    step(1);
    vec_cnt++;
    if ({bus.ch_gnt, bus.bus_busy} !== {4'b0010, 1'b1}) begin
      err_cnt++;
      $display("FAIL mr_regrant: got gnt=%b busy=%b, want 0010 1", bus.ch_gnt, bus.bus_busy);
    end
  endtask

  initial begin
    bus.init_done = 1'b0;
    bus.ch_req    = 4'b0000;
    for (int c = 0; c < N_CH; c++) begin
      set_ch(c, 4'b0000, 1'b0, 13'h0000, 2'b00, 2'b00, 16'h0000, 1'b0);
    end
    test_reset();
    test_init_grant();
    test_release();
    test_ref_priority();
    test_hold_limit();
    test_round_robin();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Registered N-channel arbiter that grants exclusive ownership of one SDRAM command/data bus to one requester at a time (init, refresh, read/write engines, etc.).
- Each grant is an explicit req/gnt handshake held until the owner releases, so a multi-cycle SDRAM sequence is never split.
- Drives NOP between owners and inserts a turnaround gap on every ownership change.
- Sits between the SDRAM controller sub-engines and the pin-level SDRAM interface.

Parameters:
N_CH, 3, number of requesting channels (2..8)
ADDR_W, 13, SDRAM address width
BA_W, 2, bank address width
DQ_W, 16, data width
DQM_W, 2, byte-mask width
INIT_CH, 0, channel allowed while init_done=0
REF_CH, 2, refresh channel; fixed highest priority once init_done=1
TURN_CYC, 1, NOP cycles after each release (1..7)
MAX_HOLD, 64, owner-hold limit in cycles while refresh waits; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
init_done  in  1  SDRAM initialisation complete
ch_req  in  N_CH  per-channel request, held for the whole transaction
ch_gnt  out  N_CH  one-hot grant
ch_cmd  in  N_CH*4  per-channel {cs_n,ras_n,cas_n,we_n}, channel i at [4i+3:4i]
ch_cke  in  N_CH  per-channel CKE
ch_addr  in  N_CH*ADDR_W  per-channel address
ch_ba  in  N_CH*BA_W  per-channel bank
ch_dqm  in  N_CH*DQM_W  per-channel byte mask
ch_dq_out  in  N_CH*DQ_W  per-channel write data
ch_dq_oe  in  N_CH  per-channel data output enable
dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each  registered command
dram_cke  out  1  registered CKE
dram_addr  out  ADDR_W  registered address
dram_ba  out  BA_W  registered bank
dram_dqm  out  DQM_W  registered byte mask
dram_dq_out  out  DQ_W  registered write data
dram_dq_oe  out  1  registered tri-state enable for the top-level DQ pad
active_ch  out  3  index of the current owner; valid when bus_busy=1
bus_busy  out  1  a channel owns the bus
refresh_urgent  out  1  refresh has waited longer than MAX_HOLD

Behaviour:
- Reset values:
  - ch_gnt=0, bus_busy=0, active_ch=0, refresh_urgent=0.
  - Command outputs at NOP: cs_n=0, ras_n=cas_n=we_n=1.
  - dram_cke=0, addr=0, ba=0, dqm=all 1, dq_out=0, dq_oe=0.
  - State=IDLE, round-robin pointer=N_CH-1.
- States:
  - IDLE: no owner.
  - OWN: one channel granted.
  - TURN: NOP gap of TURN_CYC cycles.
- Eligibility:
  - While init_done=0: only INIT_CH is eligible.
  - While init_done=1: REF_CH wins if requesting; otherwise round-robin over the remaining channels, starting at pointer+1 and wrapping at N_CH.
  - The pointer updates to the granted channel, except for REF_CH grants.
- IDLE to OWN:
  - Eligible request sampled at edge t → gnt and bus_busy high after edge t+1; active_ch is set together with gnt.
  - No eligible request → stay in IDLE.
- OWN:
  - Owner's cmd/cke/addr/ba/dqm/dq_out/dq_oe are registered to dram_* (1-cycle latency). A value driven in cycle c appears on the pins in cycle c+1.
  - Non-owner inputs are ignored.
- Release:
  - Owner req sampled low at edge r → gnt and bus_busy low after edge r+1.
  - State goes to TURN for TURN_CYC cycles with NOP, dqm=all 1, dq_oe=0.
  - Then IDLE; the earliest next grant lands TURN_CYC+1 cycles after gnt falls.
- Preemption: none; an owner is never preempted.
- CKE: dram_cke follows the owner in OWN and holds its last value in IDLE and TURN.
- Hold counter:
  - Runs while REF_CH requests, is not the owner, and state≠IDLE.
  - Saturates at MAX_HOLD; refresh_urgent=1 while count≥MAX_HOLD and MAX_HOLD≠0.
  - Clears when REF_CH is granted or drops req.
- Simultaneous events:
  - Release and new requests in the same cycle → new requests are evaluated only in IDLE, after TURN.
  - init_done rising while INIT_CH owns → no effect until release.
- Mid-operation reset: reset in any state returns all outputs to reset values on the next edge. Grant is lost immediately and no TURN is inserted.
- Out-of-range parameters (REF_CH≥N_CH, INIT_CH≥N_CH) are illegal; flag them with a simulation assertion.

Test Plan:
- Reset, init_done=0, req=3'b111 at cycle 2 → only ch0 granted at cycle 3; ch0 cmd 4'b0010 at cycle 4 appears on dram_* at cycle 5; other channels never granted.
- ch0 drops req at cycle 10, TURN_CYC=1 → gnt=0 at cycle 11; NOP at 11–12; no grant before cycle 12.
- init_done=1, ch1 and ch2 (REF_CH) request together from IDLE → ch2 granted first; ch1 granted TURN_CYC+1 cycles after ch2 releases.
- N_CH=4, REF_CH=3, ch0/1/2 request continuously, each releasing after 4 cycles → grant order 0,1,2,0,1,2 with the pointer wrapping correctly.
- MAX_HOLD=8, ch1 holds 20 cycles while ch2 requests → refresh_urgent rises after 8 cycles of waiting; ch1 keeps the bus; urgent clears the cycle after ch2's gnt.
- rst asserted while ch1 owns with dq_oe=1 → next edge: gnt=0, dq_oe=0, NOP, dram_cke=0, bus_busy=0; re-request is granted normally after rst deasserts.
